vga_fb_blitter: RTL and testbench

- Rectangle-fill engine that writes pixel words into the VGA frame buffer.
- It drives the write side of the same 13-bit-address, 16-bit-data buffer that the VGA module scans out.
- The CR16 issues one command per rectangle (duck sprite, background patch, crosshair erase) through memory-mapped registers; the blitter then streams the word writes without processor involvement.
- Memory arbitration grants the write port one word per granted cycle.

---
 rtl/vga_fb_blitter_if.sv | 32 +++
 rtl/vga_fb_blitter.sv | 145 ++++++++++++++
 tb/tb_vga_fb_blitter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vga_fb_blitter_if.sv
// Command and frame-buffer write bus of the rectangle-fill blitter.
//   cmd*    : one rectangle-fill command per cmdValid&&cmdReady handshake
//   fb*     : frame-buffer write port, one word per cycle with fbGrant high
//   status  : busy, done (one-cycle pulse), clipped (sticky)
// modport slave is the blitter side; modport master is the CPU/arbiter side.
interface vga_fb_blitter_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [6:0]  cmdX;
  logic [5:0]  cmdY;
  logic [6:0]  cmdW;
  logic [5:0]  cmdH;
  logic [15:0] cmdData;
  logic        cmdAbort;
  logic        fbWriteEn;
  logic [12:0] fbAddr;
  logic [15:0] fbData;
  logic        fbGrant;
  logic        busy;
  logic        done;
  logic        clipped;

  modport slave (
    input  cmdValid, cmdX, cmdY, cmdW, cmdH, cmdData, cmdAbort, fbGrant,
    output cmdReady, fbWriteEn, fbAddr, fbData, busy, done, clipped
  );

  modport master (
    output cmdValid, cmdX, cmdY, cmdW, cmdH, cmdData, cmdAbort, fbGrant,
    input  cmdReady, fbWriteEn, fbAddr, fbData, busy, done, clipped
  );
endinterface

// File: rtl/vga_fb_blitter.sv
// Rectangle-fill engine writing a constant word into the VGA frame buffer.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : vga_fb_blitter_if.slave (command handshake, frame-buffer write
//           port, busy/done/clipped status)
// The command is latched on accept, clipped against the FB_COLS x FB_ROWS
// buffer in SETUP, then streamed row by row; each row is followed by one
// NEXTROW cycle that advances the row base address.
module vga_fb_blitter #(
  parameter int unsigned FB_COLS = 80,
  parameter int unsigned FB_ROWS = 60
) (
  input  logic              clk,
  input  logic              reset,
  vga_fb_blitter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, NEXTROW, DONE} state_e;

  localparam logic [7:0] COLS = 8'(FB_COLS);
  localparam logic [6:0] ROWS = 7'(FB_ROWS);

  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d, w_q, w_d, eff_w_q, eff_w_d, col_q, col_d;
  logic [5:0]  y_q, y_d, h_q, h_d, eff_h_q, eff_h_d, row_q, row_d;
  logic [15:0] data_q, data_d;
  logic [12:0] row_base_q, row_base_d;
  logic        clipped_q, clipped_d;

  // Clipping of the latched command against the buffer edges.
  logic [7:0]  room_w;
  logic [6:0]  room_h;
  logic [6:0]  clip_w;
  logic [5:0]  clip_h;
  logic [12:0] setup_base;

  always_comb begin
    room_w = COLS - {1'b0, x_q};
    room_h = ROWS - {1'b0, y_q};
    if ({1'b0, x_q} >= COLS)          clip_w = '0;
    else if ({1'b0, w_q} < room_w)    clip_w = w_q;
    else                              clip_w = room_w[6:0];
    if ({1'b0, y_q} >= ROWS)          clip_h = '0;
    else if ({1'b0, h_q} < room_h)    clip_h = h_q;
    else                              clip_h = room_h[5:0];
    setup_base = 13'(y_q) * 13'(FB_COLS) + 13'(x_q);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    data_d     = data_q;
    eff_w_d    = eff_w_q;
    eff_h_d    = eff_h_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    clipped_d  = clipped_q;
    case (state_q)
      IDLE: begin
        if (bus.cmdValid) begin
          x_d       = bus.cmdX;
          y_d       = bus.cmdY;
          w_d       = bus.cmdW;
          h_d       = bus.cmdH;
          data_d    = bus.cmdData;
          clipped_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        eff_w_d    = clip_w;
        eff_h_d    = clip_h;
        clipped_d  = (clip_w != w_q) || (clip_h != h_q);
        row_base_d = setup_base;
        col_d      = '0;
        row_d      = '0;
        if (bus.cmdAbort)                        state_d = IDLE;
        else if (clip_w == '0 || clip_h == '0)   state_d = DONE;
        else                                     state_d = WRITE;
      end
      WRITE: begin
        // A grant coinciding with abort still completes that write.
        if (bus.cmdAbort) begin
          state_d = IDLE;
        end else if (bus.fbGrant) begin
          if (col_q != eff_w_q - 7'd1)      col_d   = col_q + 7'd1;
          else if (row_q != eff_h_q - 6'd1) state_d = NEXTROW;
          else                              state_d = DONE;
        end
      end
      NEXTROW: begin
        row_base_d = row_base_q + 13'(FB_COLS);
        row_d      = row_q + 6'd1;
        col_d      = '0;
        state_d    = bus.cmdAbort ? IDLE : WRITE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      data_q     <= '0;
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      clipped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      data_q     <= data_d;
      eff_w_q    <= eff_w_d;
      eff_h_q    <= eff_h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      clipped_q  <= clipped_d;
    end
  end

  assign bus.cmdReady  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.fbWriteEn = (state_q == WRITE);
  assign bus.fbAddr    = row_base_q + 13'(col_q);
  assign bus.fbData    = data_q;
  assign bus.clipped   = clipped_q;

endmodule

// File: tb/tb_vga_fb_blitter.sv
module tb_vga_fb_blitter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_fb_blitter_if bus();

  vga_fb_blitter #(.FB_COLS(80), .FB_ROWS(60)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cmd();
    bus.cmdX    = 7'($urandom);
    bus.cmdY    = 6'($urandom);
    bus.cmdW    = 7'($urandom);
    bus.cmdH    = 6'($urandom);
    bus.cmdData = 16'($urandom);
  endtask

  // Issues one command and follows it to completion against a model that
  // clips the rectangle arithmetically and lists the expected addresses.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [15:0] d, input int stall_pct, input int stall_at);
    int ew, eh, exp_done, stalls, wr_idx, stall_left;
    bit exp_clip, finished;
    int exp_q[$];
    ew = (x >= 80) ? 0 : ((w < 80 - x) ? w : 80 - x);
    eh = (y >= 60) ? 0 : ((h < 60 - y) ? h : 60 - y);
    exp_clip = (ew != w) || (eh != h);
    exp_q.delete();
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        exp_q.push_back((y + r) * 80 + x + c);
    exp_done = (ew == 0 || eh == 0) ? 2 : 1 + eh * (ew + 1);
    stalls = 0; wr_idx = 0; finished = 0;
    stall_left = (stall_at >= 0) ? 4 : 0;

    @(negedge clk);
    chk("ready_before_cmd", 32'(bus.cmdReady), 32'd1);
    bus.cmdX = 7'(x); bus.cmdY = 6'(y); bus.cmdW = 7'(w); bus.cmdH = 6'(h);
    bus.cmdData = d; bus.cmdValid = 1'b1; bus.cmdAbort = 1'b0;
    bus.fbGrant = 1'($urandom);
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("done_cycle", 32'(k), 32'(exp_done + stalls));
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        chk("clipped", 32'(bus.clipped), 32'(exp_clip));
        finished = 1;
        bus.cmdValid = 1'b0;
        bus.fbGrant = 1'b0;
        break;
      end
      chk("busy_ready", {30'd0, bus.busy, bus.cmdReady}, 32'b10);
      if (bus.fbWriteEn) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'd1, 32'd0);
          bus.fbGrant = 1'b1;
        end else begin
          chk("fb_addr", 32'(bus.fbAddr), 32'(exp_q[0]));
          chk("fb_data", 32'(bus.fbData), 32'(d));
          if (wr_idx == stall_at && stall_left > 0) begin
            bus.fbGrant = 1'b0; stall_left--; stalls++;
          end else if ($urandom_range(0, 99) < stall_pct) begin
            bus.fbGrant = 1'b0; stalls++;
          end else begin
            bus.fbGrant = 1'b1; void'(exp_q.pop_front()); wr_idx++;
          end
        end
      end else begin
        bus.fbGrant = 1'($urandom);
      end
      bus.cmdValid = 1'($urandom);
      scramble_cmd();
    end
    if (!finished) chk("done_timeout", 32'd0, 32'd1);
    bus.cmdValid = 1'b0;
    bus.fbGrant = 1'b0;
    @(negedge clk);
    chk("idle_after", {28'd0, bus.busy, bus.cmdReady, bus.done, bus.fbWriteEn}, 32'b0100);
    chk("clipped_sticky", 32'(bus.clipped), 32'(exp_clip));
  endtask

  initial begin
    bit seen;
    bus.cmdValid = 1'b0; bus.cmdAbort = 1'b0; bus.fbGrant = 1'b0;
    bus.cmdX = '0; bus.cmdY = '0; bus.cmdW = '0; bus.cmdH = '0; bus.cmdData = '0;
    #1;
    chk("reset_outputs",
        {bus.cmdReady, bus.fbWriteEn, bus.fbAddr, bus.fbData, bus.busy, bus.done, bus.clipped},
        {1'b1, 1'b0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // Basic fill, edge clip, off-screen, zero width, grant stall.
    run_cmd(2, 3, 3, 2, 16'hF00F, 0, -1);
    run_cmd(78, 59, 5, 3, 16'h1234, 0, -1);
    run_cmd(90, 10, 4, 2, 16'h5555, 0, -1);
    run_cmd(10, 0, 0, 2, 16'hAAAA, 0, -1);
    run_cmd(2, 3, 3, 2, 16'hF00F, 0, 1);

    // Abort while the second word of the rectangle is presented.
    @(negedge clk);
    bus.cmdX = 7'd2; bus.cmdY = 6'd3; bus.cmdW = 7'd3; bus.cmdH = 6'd2;
    bus.cmdData = 16'hBEEF; bus.cmdValid = 1'b1; bus.fbGrant = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.cmdValid = 1'b0;
      if (bus.fbWriteEn && bus.fbAddr == 13'd243) begin
        bus.cmdAbort = 1'b1;
        seen = 1;
        break;
      end
    end
    chk("abort_reached_243", 32'(seen), 32'd1);
    @(negedge clk);
    bus.cmdAbort = 1'b0; bus.fbGrant = 1'b0;
    chk("abort_idle", {28'd0, bus.busy, bus.cmdReady, bus.done, bus.fbWriteEn}, 32'b0100);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    run_cmd(2, 3, 3, 2, 16'hF00F, 0, -1);

    // Asynchronous reset between clock edges in the middle of a fill.
    @(negedge clk);
    bus.cmdX = 7'd78; bus.cmdY = 6'd59; bus.cmdW = 7'd5; bus.cmdH = 6'd3;
    bus.cmdData = 16'hABCD; bus.cmdValid = 1'b1; bus.fbGrant = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.cmdValid = 1'b0;
      if (bus.fbWriteEn) begin seen = 1; break; end
    end
    chk("reset_reached_write", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {bus.cmdReady, bus.fbWriteEn, bus.fbAddr, bus.fbData, bus.busy, bus.done, bus.clipped},
        {1'b1, 1'b0, 13'd0, 16'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    run_cmd(2, 3, 3, 2, 16'hF00F, 0, -1);

    // Random rectangles with random grant stalls.
    for (int i = 0; i < 24; i++) begin
      int rx, ry, rw, rh;
      rx = $urandom_range(0, 95);
      ry = $urandom_range(0, 65);
      rw = ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 12);
      rh = $urandom_range(0, 8);
      run_cmd(rx, ry, rw, rh, 16'($urandom), 30, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
